// File: rtl/rnn_pkg.sv
// rnn_pkg: shared types, register addresses, FSM states and status bit positions for rnn_cell_param
package rnn_pkg;
  localparam int DW_DEFAULT = 16;
  typedef logic signed [DW_DEFAULT-1:0] elem_t;
  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_X = 3'd1;
  localparam logic [2:0] ADDR_W = 3'd2;
  localparam logic [2:0] ADDR_U = 3'd3;
  localparam logic [2:0] ADDR_B = 3'd4;
  localparam logic [2:0] ADDR_HRD = 3'd5;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF = 2;
  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;
endpackage

// File: rtl/rnn_mac.sv
// rnn_mac: bias-loaded multiply-accumulator with output formatting; RNN_SAT_EN selects saturation instead of wrap
module rnn_mac #(
  parameter int DW = 16,
  parameter int ACC_W = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic signed [DW-1:0] bias,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] res,
  output logic sat
);
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [2*DW-1:0] prod;
  logic hi, lo;
  assign prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
  assign sum = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign hi = !sum[ACC_W-1] && |sum[ACC_W-2:DW-1];
  assign lo = sum[ACC_W-1] && !(&sum[ACC_W-2:DW-1]);
`ifdef RNN_SAT_EN
  assign res = hi ? {1'b0, {(DW-1){1'b1}}} : lo ? {1'b1, {(DW-1){1'b0}}} : sum[DW-1:0];
  assign sat = hi || lo;
`else
  assign res = sum[DW-1:0];
  assign sat = 1'b0;
  logic unused_range;
  assign unused_range = hi ^ lo;
`endif
  // accumulator: bias preload at row start, exact accumulation otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= load ? {{(ACC_W-DW){bias[DW-1]}}, bias} : en ? sum : acc;
endmodule

// File: rtl/rnn_cell_param.sv
// rnn_cell_param: parametrised Elman RNN cell behind an Avalon-MM-style slave; RNN_SAT_EN enables saturating outputs
module rnn_cell_param
  import rnn_pkg::*;
#(
  parameter int EMB_DIM = 2,
  parameter int HID_DIM = 4,
  parameter int DW = 16,
  parameter int ACC_W = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic read,
  input  logic write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);
  localparam int NT = EMB_DIM + HID_DIM;
  typedef logic signed [DW-1:0] el_t;
  el_t x [EMB_DIM];
  el_t w [EMB_DIM][HID_DIM];
  el_t u [HID_DIM][HID_DIM];
  el_t b [HID_DIM];
  el_t h_old [HID_DIM];
  el_t h_new [HID_DIM];
  el_t op_a, op_b, b_nx, mac_bias, res, h_rd;
  state_t state, state_nx;
  logic [8:0] k;
  logic [7:0] j, rd_idx;
  logic busy, done, ovf, sat, wr_ok, start, clr_h, last_k, last_j, mac_load, mac_en;
  logic unused_bits;
  assign unused_bits = ^{addr[31:3], data_in, sat};
  assign busy = state != IDLE;
  assign wr_ok = write && !busy;
  assign start = wr_ok && addr[2:0] == ADDR_CTRL && data_in[0];
  assign clr_h = wr_ok && addr[2:0] == ADDR_CTRL && data_in[1];
  assign last_k = k == 9'(NT - 1);
  assign last_j = j == 8'(HID_DIM - 1);
  assign mac_load = start || (state == RUN && last_k && !last_j);
  assign mac_en = state == RUN && !last_k;
  assign mac_bias = start ? b[0] : b_nx;
  rnn_mac #(.DW(DW), .ACC_W(ACC_W)) mac (
    .clk(clk), .rst(rst), .load(mac_load), .en(mac_en), .bias(mac_bias),
    .a(op_a), .b(op_b), .res(res), .sat(sat)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: IDLE -> RUN on START, RUN -> COMMIT after the last term of the last row
  always_comb begin
    state_nx = (state == IDLE && start) ? RUN :
               (state == RUN && last_k && last_j) ? COMMIT :
               (state == COMMIT) ? IDLE : state;
  end
  // operand selection: input terms first, then recurrent terms from h_old; bias of the next row
  always_comb begin
    op_a = '0;
    op_b = '0;
    b_nx = '0;
    for (int i = 0; i < EMB_DIM; i++)
      for (int c = 0; c < HID_DIM; c++)
        if (k == 9'(i) && j == 8'(c)) begin
          op_a = x[i];
          op_b = w[i][c];
        end
    for (int i = 0; i < HID_DIM; i++)
      for (int c = 0; c < HID_DIM; c++)
        if (k == 9'(EMB_DIM + i) && j == 8'(c)) begin
          op_a = h_old[i];
          op_b = u[i][c];
        end
    for (int c = 0; c < HID_DIM; c++)
      if (j + 8'd1 == 8'(c)) b_nx = b[c];
  end
  // parameter and input storage; frozen while busy except the read-back index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < EMB_DIM; i++) begin
        x[i] <= '0;
        for (int c = 0; c < HID_DIM; c++) w[i][c] <= '0;
      end
      for (int i = 0; i < HID_DIM; i++) begin
        b[i] <= '0;
        for (int c = 0; c < HID_DIM; c++) u[i][c] <= '0;
      end
      rd_idx <= '0;
    end else if (write) begin
      if (addr[2:0] == ADDR_HRD) rd_idx <= data_in[7:0];
      if (!busy) begin
        for (int i = 0; i < EMB_DIM; i++) begin
          if (addr[2:0] == ADDR_X && data_in[31:16] == 16'(i)) x[i] <= data_in[DW-1:0];
          for (int c = 0; c < HID_DIM; c++)
            if (addr[2:0] == ADDR_W && data_in[31:24] == 8'(i) && data_in[23:16] == 8'(c)) w[i][c] <= data_in[DW-1:0];
        end
        for (int i = 0; i < HID_DIM; i++) begin
          if (addr[2:0] == ADDR_B && data_in[31:16] == 16'(i)) b[i] <= data_in[DW-1:0];
          for (int c = 0; c < HID_DIM; c++)
            if (addr[2:0] == ADDR_U && data_in[31:24] == 8'(i) && data_in[23:16] == 8'(c)) u[i][c] <= data_in[DW-1:0];
        end
      end
    end
  // sequencing and double-buffered hidden state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < HID_DIM; i++) begin
        h_old[i] <= '0;
        h_new[i] <= '0;
      end
      k <= '0;
      j <= '0;
      done <= 1'b0;
    end else begin
      if (clr_h)
        for (int i = 0; i < HID_DIM; i++) begin
          h_old[i] <= '0;
          h_new[i] <= '0;
        end
      if (start) begin
        k <= '0;
        j <= '0;
        done <= 1'b0;
      end
      if (state == RUN) begin
        k <= last_k ? '0 : k + 9'd1;
        if (last_k) begin
          for (int c = 0; c < HID_DIM; c++)
            if (j == 8'(c)) h_new[c] <= res;
          j <= j + 8'd1;
        end
      end
      if (state == COMMIT) begin
        h_old <= h_new;
        done <= 1'b1;
      end
    end
`ifdef RNN_SAT_EN
  // sticky overflow: any clamped row result since the last START
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (start) ovf <= 1'b0;
    else if (state == RUN && last_k && sat) ovf <= 1'b1;
`else
  assign ovf = 1'b0;
`endif
  // read-back selection of the committed hidden state
  always_comb begin
    h_rd = '0;
    for (int i = 0; i < HID_DIM; i++)
      if (rd_idx == 8'(i)) h_rd = h_old[i];
  end
  // registered read data, held when no read
  always_ff @(posedge clk or posedge rst)
    if (rst) data_out <= '0;
    else if (read) data_out <= addr[2:0] == ADDR_CTRL ? {29'b0, ovf, done, busy} :
                               addr[2:0] == ADDR_HRD ? 32'(h_rd) : '0;
endmodule

// File: tb/tb_rnn_cell_param.sv
// tb_rnn_cell_param: directed table-driven bench for rnn_cell_param (default parameters)
module tb_rnn_cell_param;
  logic clk = 1'b0;
  logic rst, read, write;
  logic [31:0] addr, data_in, data_out;
  int errors = 0;
  int checks = 0;
  rnn_cell_param dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .addr(addr), .data_in(data_in), .data_out(data_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    int x0;
    int x1;
    int e [4];
  } step_t;
  step_t steps [2];
  int wi [2][4] = '{'{2, -10, -10, 3}, '{6, 9, 12, 1}};
  int ui [4][4] = '{'{-2, -3, -5, -3}, '{-1, 10, -2, -6}, '{4, 11, 3, -12}, '{-11, -4, 3, -1}};
  int bi [4] = '{-2, -2, -1, -1};
  int res1 [4] = '{-16, -49, -57, 2};
  int zero4 [4] = '{0, 0, 0, 0};
  int sat4 [4];
  int cyc;
  logic [31:0] st, v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1;
    addr = 32'(a);
    data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    read = 1'b1;
    addr = 32'(a);
    @(negedge clk);
    read = 1'b0;
    d = data_out;
  endtask

  task automatic run_and_wait(output int n, output logic [31:0] s);
    n = 0;
    addr = 32'd0;
    read = 1'b1;
    @(negedge clk);
    while (data_out[0] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    s = data_out;
    read = 1'b0;
  endtask

  task automatic chk_h(input string tag, input int e [4]);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      wr(5, 32'(i));
      rd(5, r);
      chk($sformatf("%s h[%0d]", tag, i), $signed(r), e[i]);
    end
  endtask

  initial begin
    steps[0].x0 = 2;
    steps[0].x1 = -3;
    steps[0].e = '{-16, -49, -57, 2};
    steps[1].x0 = -8;
    steps[1].x1 = 3;
    steps[1].e = '{-169, -972, 128, 1002};
`ifdef RNN_SAT_EN
    sat4 = '{32767, 0, 0, 0};
`else
    sat4 = '{2, 0, 0, 0};
`endif
    rst = 1'b1;
    read = 1'b0;
    write = 1'b0;
    addr = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset data_out", int'(data_out), 0);
    rd(0, v);
    chk("reset status", int'(v), 0);
    chk_h("reset", zero4);

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) wr(2, {8'(r), 8'(c), 16'(wi[r][c])});
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(3, {8'(r), 8'(c), 16'(ui[r][c])});
    for (int c = 0; c < 4; c++) wr(4, {16'(c), 16'(bi[c])});

    for (int s = 0; s < 2; s++) begin
      wr(1, {16'd0, 16'(steps[s].x0)});
      wr(1, {16'd1, 16'(steps[s].x1)});
      wr(0, 32'd1);
      run_and_wait(cyc, st);
      chk($sformatf("step%0d busy cycles", s), cyc, 25);
      chk($sformatf("step%0d status", s), int'(st), 2);
      chk_h($sformatf("step%0d", s), steps[s].e);
    end

    wr(0, 32'd2);
    chk_h("clear_h", zero4);
    wr(1, {16'd0, 16'(2)});
    wr(1, {16'd1, 16'(-3)});
    wr(0, 32'd1);
    wr(2, {8'd0, 8'd0, 16'd99});
    wr(1, {16'd0, 16'd7});
    wr(5, 32'd2);
    run_and_wait(cyc, st);
    chk("busy-write status", int'(st), 2);
    rd(5, v);
    chk("rd_idx write while busy", $signed(v), -57);
    chk_h("busy-write", res1);

    wr(1, {16'd200, 16'd5});
    wr(2, {8'd9, 8'd0, 16'd5});
    wr(0, 32'd3);
    run_and_wait(cyc, st);
    chk("clear+start busy cycles", cyc, 25);
    chk_h("out-of-range", res1);
    wr(5, 32'd4);
    rd(5, v);
    chk("rd_idx out of range", int'(v), 0);

    wr(0, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(0, v);
    chk("mid-run reset status", int'(v), 0);
    chk_h("mid-run reset", zero4);

    wr(1, {16'd0, 16'h7fff});
    wr(1, {16'd1, 16'h7fff});
    wr(2, {8'd0, 8'd0, 16'h7fff});
    wr(2, {8'd1, 8'd0, 16'h7fff});
    wr(0, 32'd1);
    run_and_wait(cyc, st);
`ifdef RNN_SAT_EN
    chk("overflow status", int'(st), 6);
`else
    chk("overflow status", int'(st), 2);
`endif
    chk_h("overflow", sat4);
    wr(0, 32'd1);
    run_and_wait(cyc, st);
    rd(0, v);
`ifdef RNN_SAT_EN
    chk("ovf after restart", int'(v), 6);
`else
    chk("ovf after restart", int'(v), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rnn_cell_param.md
Name: rnn_cell_param

Overview:
- Parametrised Elman RNN cell with an Avalon-MM-style slave interface, generalising the fixed 2-input/4-hidden rnn block.
- Computes h_new[j] = b[j] + sum_i x[i]*W[i][j] + sum_k h_old[k]*U[k][j] with one time-multiplexed MAC.
- Hidden state persists across START commands, so successive input vectors form a sequence.
- Adds read-back of hidden state and status, an explicit hidden-state clear, and optional saturating arithmetic.

Parameters:
- EMB_DIM, 2, input vector length E (1..255).
- HID_DIM, 4, hidden vector length H (1..255).
- DW, 16, signed element width for x, W, U, b and h.
- ACC_W, 40, signed accumulator width; must be at least 2*DW + clog2(E+H+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- read  in  1  read strobe.
- write  in  1  write strobe.
- addr  in  32  register address (bits [2:0] decoded, upper bits ignored).
- data_in  in  32  write data.
- data_out  out  32  read data, registered.

Behaviour:
- Register map for writes:
  - addr 0: bit0=START, bit1=CLEAR_H.
  - addr 1: x[data_in[31:16]] <= data_in[DW-1:0].
  - addr 2: W[data_in[31:24]][data_in[23:16]] <= data_in[DW-1:0] (row = input index, col = hidden index).
  - addr 3: U[data_in[31:24]][data_in[23:16]] <= value (row = old-hidden index, col = hidden index).
  - addr 4: b[data_in[31:16]] <= value.
  - addr 5: rd_idx <= data_in[7:0].
- Out-of-range indices are ignored silently. Writes to addr 1-5 take effect on the same clock edge.
- Reads, with data_out valid the cycle after read (read latency 1):
  - addr 0: {29'b0, ovf, done, busy}.
  - addr 5: sign-extended h_old[rd_idx], or 0 if out of range.
  - All other addresses: 0.
- data_out holds its value when read=0.
- Reset: state=IDLE; all x, W, U, b, h_old, h_new, counters, acc and rd_idx cleared to 0; data_out=0; busy=done=ovf=0. Reset mid-RUN aborts the computation and clears everything.
- FSM IDLE:
  - START -> RUN; clears done and ovf; row j=0, term k=0, acc=sext(b[0]).
  - CLEAR_H (START=0) zeroes h_old and h_new in one cycle.
  - START and CLEAR_H written together: the clear applies first, then RUN starts from h_old=0.
- FSM RUN, one MAC per cycle:
  - Term k<E adds x[k]*W[k][j]; term k>=E adds h_old[k-E]*U[k-E][j].
  - On k=E+H-1, h_new[j] <= fmt(acc + product), then j++, k=0, acc=sext(b[j+1]).
  - After j=H-1 -> COMMIT.
- FSM COMMIT: h_old <= h_new for all elements at once; done<=1 (sticky until the next START); -> IDLE.
- busy=1 in RUN and COMMIT. With defaults, busy lasts H*(E+H)+1 = 25 cycles, and done is readable starting the cycle after the last busy cycle.
- Writes to addr 0-4 while busy are ignored; x/W/U/b are stable during computation. addr 5 writes and all reads remain allowed.
- Every row uses h_old only (double buffering), so row ordering cannot corrupt the recurrence.
- Arithmetic: products are full 2*DW signed; accumulation is exact in ACC_W. fmt() is defined under Optional Feature.

Optional Feature:
- Macro: RNN_SAT_EN.
- Defined: fmt() clamps to [-2^(DW-1), 2^(DW-1)-1]. Any clamp sets sticky ovf (status bit2), which is cleared by START or reset.
- Undefined: fmt() keeps the low DW bits (two's-complement wrap, matching the first-generation block); ovf is tied to 0.

Decomposition:
- Package rnn_pkg:
  - elem_t (logic signed [DW-1:0] via a parameterised typedef in the package or localparam DW_DEFAULT).
  - Address localparams ADDR_CTRL=0, ADDR_X=1, ADDR_W=2, ADDR_U=3, ADDR_B=4, ADDR_HRD=5.
  - State enum {IDLE, RUN, COMMIT}.
  - Status bit positions.
- One sub-module, rnn_mac: clear/load-bias, multiply-accumulate, and fmt with the saturation/overflow output.

Test Plan:
- Reset, write x=(2,-3), W rows (2,-10,-10,3)/(6,9,12,1), U rows (-2,-3,-5,-3)/(-1,10,-2,-6)/(4,11,3,-12)/(-11,-4,3,-1), b=(-2,-2,-1,-1), then START -> busy for exactly 25 cycles; done=1; h read via addr 5 = (-16,-49,-57,2).
- Then x=(-8,3) and START -> h = (-169,-972,128,1002), which proves the recurrence uses the previous h_old.
- Write W[0][0]=99 and x[0]=7 while busy -> ignored; result unchanged. A write to addr 5 while busy is accepted.
- CLEAR_H in IDLE, then repeat step 1 -> h = (-16,-49,-57,2). Assert rst mid-RUN -> status reads 0 and every h reads 0.
- Set x=(32767,32767), W[0][0]=W[1][0]=32767, other weights and biases 0, then START -> h[0]=32767 with ovf=1 under RNN_SAT_EN; h[0]=2 with ovf=0 without it.
- Write with index 200 on addr 1 and with row 9 on addr 2 -> no state change. A read at addr 5 with rd_idx=4 -> 0.
